// File: rtl/alu_bist_pkg.sv
// ============================================================================
// Module : picoMIPS_package
// Brief  : Shared ALU function codes, BIST states and the golden ALU model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package picoMIPS_package;

    localparam int DATA_WIDTH = 8;
    // Widest operand the golden model supports
    localparam int MAX_W      = 16;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Maps the sweep's function index (0..3) onto an ALU function code.
    function automatic logic [2:0] func_code(input logic [1:0] idx);
        logic [2:0] c;
        case (idx)
            2'd0:    c = ALU_ADD;
            2'd1:    c = ALU_SUB;
            2'd2:    c = ALU_AND;
            default: c = ALU_MUL;
        endcase
        return c;
    endfunction

    // Golden ALU result for a w-bit datapath; MUL keeps the Q1.(w-1) product.
    function automatic logic [MAX_W-1:0] alu_model(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [2:0]       ctrl,
        input int               w = DATA_WIDTH
    );
        logic [MAX_W-1:0]          mask;
        logic signed [2*MAX_W-1:0] sa;
        logic signed [2*MAX_W-1:0] sb;
        logic signed [2*MAX_W-1:0] prod;
        logic [MAX_W-1:0]          r;
        mask = MAX_W'((32'd1 << w) - 32'd1);
        sa   = $signed({{MAX_W{1'b0}}, a & mask});
        sb   = $signed({{MAX_W{1'b0}}, b & mask});
        sa   = (sa <<< (2*MAX_W - w)) >>> (2*MAX_W - w);
        sb   = (sb <<< (2*MAX_W - w)) >>> (2*MAX_W - w);
        prod = sa * sb;
        case (ctrl)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_MUL: r = MAX_W'(prod >>> (w - 1));
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bist_vecgen.sv
// ============================================================================
// Module : alu_bist_vecgen
// Brief  : Operand/function sweep counters for the ALU BIST (B inner, A middle).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_bist_vecgen
    import picoMIPS_package::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [2:0]            o_ctrl,
    output logic                  o_last_vec
);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [1:0]            r_fidx;
    logic [2:0]            r_ctrl;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_a    <= '0;
            r_b    <= '0;
            r_fidx <= 2'd0;
            r_ctrl <= ALU_ADD;
        end else if (i_advance) begin
            r_b <= r_b + 1'b1;
            if (&r_b) begin
                r_a <= r_a + 1'b1;
                // Function code is registered alongside its index so ctrl is glitch-free
                if (&r_a) begin
                    r_fidx <= r_fidx + 2'd1;
                    r_ctrl <= func_code(r_fidx + 2'd1);
                end
            end
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_ctrl     = r_ctrl;
    assign o_last_vec = (r_fidx == 2'd3) && (&r_a) && (&r_b);

endmodule

`default_nettype wire

// File: rtl/alu_bist.sv
// ============================================================================
// Module : alu_bist
// Brief  : Built-in self-test sweeping every operand pair and function of the ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_bist
    import picoMIPS_package::*;
#(
    parameter int DATA_WIDTH = picoMIPS_package::DATA_WIDTH,
    parameter int ERR_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic signed [DATA_WIDTH-1:0] A,
    output logic signed [DATA_WIDTH-1:0] B,
    output logic [2:0]                   ctrl,
    input  logic signed [DATA_WIDTH-1:0] result,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ERR_W-1:0]             err_count,
    output logic [DATA_WIDTH-1:0]        fail_A,
    output logic [DATA_WIDTH-1:0]        fail_B,
    output logic [2:0]                   fail_ctrl,
    output logic [DATA_WIDTH-1:0]        fail_result
);

    bist_state_t           r_state;
    bist_state_t           w_state_next;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_last_vec;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [2:0]            w_ctrl;
    logic [DATA_WIDTH-1:0] w_expected;
    logic [ERR_W-1:0]      r_err_count;
    logic [ERR_W-1:0]      w_err_next;
    logic                  r_pass;
    logic [DATA_WIDTH-1:0] r_fail_a;
    logic [DATA_WIDTH-1:0] r_fail_b;
    logic [2:0]            r_fail_ctrl;
    logic [DATA_WIDTH-1:0] r_fail_result;

    alu_bist_vecgen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_vecgen (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .o_a        (w_a),
        .o_b        (w_b),
        .o_ctrl     (w_ctrl),
        .o_last_vec (w_last_vec)
    );

    assign w_expected = DATA_WIDTH'(alu_model(MAX_W'(w_a), MAX_W'(w_b), w_ctrl, DATA_WIDTH));
    assign w_mismatch = (r_state == RUN) && ($unsigned(result) != w_expected);
    assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // The last vector is left on A/B/ctrl so the port holds in IDLE
                if (w_last_vec) begin
                    w_state_next = DONE;
                end else begin
                    w_advance = 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_err_count   <= '0;
            r_pass        <= 1'b0;
            r_fail_a      <= '0;
            r_fail_b      <= '0;
            r_fail_ctrl   <= 3'b000;
            r_fail_result <= '0;
        end else if (r_state == RUN) begin
            r_err_count <= w_err_next;
            if (w_mismatch && (r_err_count == '0)) begin
                r_fail_a      <= w_a;
                r_fail_b      <= w_b;
                r_fail_ctrl   <= w_ctrl;
                r_fail_result <= $unsigned(result);
            end
            // Includes the final vector's outcome so pass is valid alongside done
            if (w_last_vec) begin
                r_pass <= (w_err_next == '0);
            end
        end
    end

    assign A           = w_a;
    assign B           = w_b;
    assign ctrl        = w_ctrl;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign pass        = r_pass;
    assign err_count   = r_err_count;
    assign fail_A      = r_fail_a;
    assign fail_B      = r_fail_b;
    assign fail_ctrl   = r_fail_ctrl;
    assign fail_result = r_fail_result;

endmodule

`default_nettype wire

// File: doc/alu_bist.md
# alu_bist

Synthesizable built-in self-test controller for the picoMIPS ALU. On `start` it drives every operand pair for each supported ALU function into the combinational `alu`. It checks each `result` against an internal golden model, counts mismatches and captures the first failing vector. It sits beside `alu` and drives the same `A`/`B`/`ctrl` port as the datapath, behind a test-mode mux outside this block. It also consumes the ALU's `result`.

## Interface
Parameters:
- `DATA_WIDTH`, default `picoMIPS_package::DATA_WIDTH` (8): operand/result width; benches may override to 4.
- `ERR_W`, default 16: error counter width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `A`  out  DATA_WIDTH signed  operand A to alu, registered.
- `B`  out  DATA_WIDTH signed  operand B to alu, registered.
- `ctrl`  out  3  ALU function to alu, registered.
- `result`  in  DATA_WIDTH signed  alu output, combinational from `A`/`B`/`ctrl`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `pass`  out  1  high from DONE until the next start, iff `err_count`==0.
- `err_count`  out  ERR_W  mismatch count, saturating.
- `fail_A`, `fail_B`  out  DATA_WIDTH  operands of the first mismatch.
- `fail_ctrl`  out  3  function of the first mismatch.
- `fail_result`  out  DATA_WIDTH  alu result at the first mismatch.

## Operation
- Function codes come from the package: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_MUL=3'b100.
- Golden model, all arithmetic modulo 2^DATA_WIDTH:
  - ADD: A+B.
  - SUB: A−B.
  - AND: A&B.
  - MUL: signed A×B to 2·DATA_WIDTH bits; bits [2·DATA_WIDTH−2 : DATA_WIDTH−1] (fractional Q1.(N−1) product).
- Sweep order: function index outer (ADD, SUB, AND, MUL), `A` middle 0..2^N−1, `B` inner 0..2^N−1. Values are unsigned bit patterns.
- Total vectors: 4·2^(2N).
- States:
  - IDLE: outputs hold. `start` → load `A`=`B`=0, `ctrl`=ALU_ADD, clear `err_count` and the fail registers, go to RUN.
  - RUN: every cycle compare `result` with the model of the current `A`/`B`/`ctrl`.
    - On mismatch: `err_count`+1, saturating at all-ones.
    - If `err_count` was 0 before the increment, latch the fail_* registers.
    - Then advance the vector. After the last vector (MUL, all-ones, all-ones) is checked, go to DONE.
  - DONE: `done`=1 for one cycle, `pass` set, go to IDLE.
- In RUN and DONE, `start` is ignored.

## Timing
- Reset values: `A`=`B`=0, `ctrl`=ALU_ADD, `busy`=`done`=`pass`=0, `err_count`=0, fail_*=0, state IDLE.
- `start` high at edge k:
  - `busy` is high from edge k+1.
  - The first vector is compared in cycle k+1.
  - Vector n is compared in cycle k+1+n, one vector per cycle.
- Let V = 4·2^(2N):
  - `busy` falls at edge k+1+V.
  - `done` is high in cycle k+1+V only.
  - `pass` goes valid at that same edge.
- A mismatch at vector n increments `err_count`, visible at edge k+2+n.
- Wrap: `B` wraps to 0 and `A` increments. When `A` and `B` both wrap, `ctrl` steps to the next code.
- Reset mid-sweep: the next edge returns to IDLE with every output at its reset value. There is no partial `done`.
- `start` held continuously: a new sweep begins on the cycle after DONE, and `pass` is cleared then.

## Structure
- picoMIPS_package gains:
  - the ALU_* function constants;
  - a `bist_state_t` enum {IDLE, RUN, DONE};
  - a function `alu_model(a, b, ctrl)` returning the golden result.
- `alu` is also written against this package function, so the package is the single source of truth.
- One sub-module: `alu_bist_vecgen`, holding the A/B/function-index counters and a `last_vec` flag.
- Compare logic and FSM stay in `alu_bist`.

## Test plan
- Correct ALU, DATA_WIDTH=4, pulse `start`:
  - `busy` is high for exactly 1024 cycles;
  - `done` pulses once;
  - `pass`=1, `err_count`=0.
- Fault-injected alu (MUL result bit 0 inverted), DATA_WIDTH=4:
  - `err_count`=256;
  - `fail_ctrl`=3'b100, `fail_A`=0, `fail_B`=0, `fail_result`=1;
  - `pass`=0.
- Single-vector fault (ADD returns 0 only for A=4'h3, B=4'h5):
  - `err_count`=1;
  - `fail_A`=3, `fail_B`=5, `fail_ctrl`=0, `fail_result`=0.
- Mid-sweep reset: assert `reset` at cycle 300 of RUN.
  - Next cycle: IDLE, `busy`=0, `A`=`B`=0, `err_count`=0.
  - A following `start` runs a full 1024-cycle sweep.
- Always-wrong alu with ERR_W=8: `err_count` saturates at 255. `start` pulsed during RUN has no effect on vector order or length.
- DATA_WIDTH=8 spot check (model only): MUL of 8'h40 × 8'h40 gives 8'h20, and of 8'h80 × 8'h80 gives 8'h80. The bench model agrees with `alu_model`.
